// File: rtl/uart_tx_port.sv
`default_nettype none
// ============================================================================
//  Module      : uart_tx_port
//  Description : CPU output-port UART transmitter. Bytes written through the
//                port are queued in a small circular FIFO and shifted out as
//                8N1 frames on a registered, idle-high serial line. A status
//                byte {5'b0, overflow, full, busy} lets software poll for room.
//                Optional even parity is enabled by defining the macro
//                UART_TX_PARITY_EN (adds a PARITY bit between DATA and STOP).
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_port #(
    parameter int CLKS_PER_BIT = 16,
    parameter int DEPTH        = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       wr,
    input  logic [7:0] din,
    output logic       tx,
    output logic       busy,
    output logic       full,
    output logic [7:0] status
);

    // Baud counter just wide enough for 0..CLKS_PER_BIT-1.
    localparam int c_baud_w = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    // Pointers carry one extra wrap bit to tell full from empty.
    localparam int c_ptr_w  = $clog2(DEPTH);

    localparam logic [c_baud_w-1:0] c_baud_last = c_baud_w'(CLKS_PER_BIT - 1);
    localparam logic [c_baud_w-1:0] c_baud_one  = c_baud_w'(1);
    localparam logic [c_ptr_w:0]    c_ptr_one   = (c_ptr_w + 1)'(1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
        S_PARITY = 3'd4,
`endif
        S_STOP   = 3'd3
    } state_t;

    // ------------------------------------------------------------------------
    // FIFO storage and pointers
    // ------------------------------------------------------------------------
    logic [7:0]          r_mem [DEPTH];
    logic [c_ptr_w:0]    r_wptr;
    logic [c_ptr_w:0]    r_rptr;
    logic                r_overflow;

    logic                w_empty;
    logic                w_full;
    logic                w_wr_ok;
    logic [7:0]          w_head;

    // ------------------------------------------------------------------------
    // Transmitter state
    // ------------------------------------------------------------------------
    state_t              r_state;
    state_t              w_state_next;
    logic [c_baud_w-1:0] r_baud;
    logic [c_baud_w-1:0] w_baud_next;
    logic [2:0]          r_bit;
    logic [2:0]          w_bit_next;
    logic [7:0]          r_shift;
    logic [7:0]          w_shift_next;
    logic                r_tx;
    logic                w_tx_next;
    logic                r_busy;
    logic                w_pop;
    logic                w_baud_last;
`ifdef UART_TX_PARITY_EN
    logic                r_parity;
`endif

    assign w_empty     = (r_wptr == r_rptr);
    assign w_full      = (r_wptr[c_ptr_w] != r_rptr[c_ptr_w]) &&
                         (r_wptr[c_ptr_w-1:0] == r_rptr[c_ptr_w-1:0]);
    // Full is judged on the pre-edge pointers, so a write landing in the
    // same cycle a slot drains is still dropped.
    assign w_wr_ok     = wr && !w_full;
    assign w_head      = r_mem[r_rptr[c_ptr_w-1:0]];
    assign w_baud_last = (r_baud == c_baud_last);

    // FIFO payload write; contents need no reset because pointers gate reads.
    always_ff @(posedge clk) begin
        if (w_wr_ok) begin
            r_mem[r_wptr[c_ptr_w-1:0]] <= din;
        end
    end

    // FIFO pointers and the sticky overflow flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_wr_ok) begin
                r_wptr <= r_wptr + c_ptr_one;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + c_ptr_one;
            end
            if (wr && w_full) begin
                r_overflow <= 1'b1;
            end
        end
    end

    // Next-state logic: frame sequencing, baud/bit counting and FIFO pops.
    always_comb begin
        w_state_next = r_state;
        w_baud_next  = w_baud_last ? '0 : (r_baud + c_baud_one);
        w_bit_next   = r_bit;
        w_shift_next = r_shift;
        w_pop        = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_baud_next = '0;
                if (!w_empty) begin
                    w_pop        = 1'b1;
                    w_shift_next = w_head;
                    w_state_next = S_START;
                end
            end
            S_START: begin
                if (w_baud_last) begin
                    w_state_next = S_DATA;
                    w_bit_next   = 3'd0;
                end
            end
            S_DATA: begin
                if (w_baud_last) begin
                    w_shift_next = {1'b0, r_shift[7:1]};
                    if (r_bit == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        w_state_next = S_PARITY;
`else
                        w_state_next = S_STOP;
`endif
                    end else begin
                        w_bit_next = r_bit + 3'd1;
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            S_PARITY: begin
                if (w_baud_last) begin
                    w_state_next = S_STOP;
                end
            end
`endif
            S_STOP: begin
                // Chain straight into the next frame when data is waiting.
                if (w_baud_last) begin
                    if (!w_empty) begin
                        w_pop        = 1'b1;
                        w_shift_next = w_head;
                        w_state_next = S_START;
                    end else begin
                        w_state_next = S_IDLE;
                    end
                end
            end
            default: begin
                w_state_next = S_IDLE;
                w_baud_next  = '0;
            end
        endcase
    end

    // Line level for the state being entered, so tx is a clean register.
    always_comb begin
        w_tx_next = 1'b1;
        case (w_state_next)
            S_START:  w_tx_next = 1'b0;
            S_DATA:   w_tx_next = w_shift_next[0];
`ifdef UART_TX_PARITY_EN
            S_PARITY: w_tx_next = r_parity;
`endif
            default:  w_tx_next = 1'b1;
        endcase
    end

    // Transmitter registers, including the registered tx and busy outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_baud  <= '0;
            r_bit   <= 3'd0;
            r_shift <= 8'h00;
            r_tx    <= 1'b1;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_baud  <= w_baud_next;
            r_bit   <= w_bit_next;
            r_shift <= w_shift_next;
            r_tx    <= w_tx_next;
            r_busy  <= (w_state_next != S_IDLE) || !w_empty;
        end
    end

`ifdef UART_TX_PARITY_EN
    // Even parity of the byte captured at pop time; the shifter is consumed.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_parity <= 1'b0;
        end else if (w_pop) begin
            r_parity <= ^w_head;
        end
    end
`endif

    assign tx     = r_tx;
    assign busy   = r_busy;
    assign full   = w_full;
    assign status = {5'b0_0000, r_overflow, w_full, r_busy};

endmodule
`default_nettype wire
